// File: rtl/hyperbus_delay_pkg.sv
// Shared types and helpers for the HyperBus RWDS delay-line calibration controller.
package hyperbus_delay_pkg;

   localparam int DEFAULT_NUM_TAPS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_TAP,
      S_SETTLE,
      S_REQ,
      S_WAIT,
      S_EVAL,
      S_DONE
   } calib_state_t;

   function automatic int tap_w(input int num_taps);
      return (num_taps > 1) ? $clog2(num_taps) : 1;
   endfunction

endpackage

// File: rtl/hyperbus_delay_window.sv
// Tracks the current run of passing taps and the longest run seen so far;
// only a strictly longer run replaces the best, so the earliest run wins ties.
module hyperbus_delay_window #(
   parameter int TAP_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             score_i,
   input  logic             pass_i,
   input  logic [TAP_W-1:0] tap_i,
   output logic [TAP_W-1:0] best_start_o,
   output logic [TAP_W:0]   best_len_o
);

   logic [TAP_W-1:0] cur_start;
   logic [TAP_W:0]   cur_len;
   logic [TAP_W-1:0] run_start;
   logic [TAP_W:0]   run_len;

   // Run as it would look if the tap being scored passes.
   always_comb begin
      run_len   = cur_len + (TAP_W+1)'(1);
      run_start = (cur_len == '0) ? tap_i : cur_start;
   end

   // Comparing against the extended run on every pass means a run that ends
   // on the last tap is already accounted for when the sweep finishes.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      if (!rst_ni || clear_i) begin
         cur_start    <= '0;
         cur_len      <= '0;
         best_start_o <= '0;
         best_len_o   <= '0;
      end else if (score_i) begin
         if (pass_i) begin
            cur_start <= run_start;
            cur_len   <= run_len;
            if (run_len > best_len_o) begin
               best_start_o <= run_start;
               best_len_o   <= run_len;
            end
         end else begin
            cur_len <= '0;
         end
      end
   end

endmodule

// File: rtl/hyperbus_delay_calib.sv
// RWDS delay-line tap controller: forwards a manual tap or sweeps all taps with
// training reads and programs the centre of the longest passing window.
module hyperbus_delay_calib
   import hyperbus_delay_pkg::*;
#(
   parameter int  NUM_TAPS       = DEFAULT_NUM_TAPS,
   parameter int  SETTLE_CYCLES  = 4,
   parameter int  TIMEOUT_CYCLES = 256,
   localparam int TAP_W          = tap_w(NUM_TAPS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_manual_i,
   input  logic [31:0]      cfg_delay_i,
   input  logic             calib_start_i,
   input  logic             bus_idle_i,
   output logic             trn_req_o,
   input  logic             trn_gnt_i,
   input  logic             trn_done_i,
   input  logic             trn_pass_i,
   output logic [31:0]      delay_o,
   output logic             calib_busy_o,
   output logic             calib_done_o,
   output logic             calib_err_o,
   output logic [TAP_W-1:0] calib_tap_o,
   output logic [TAP_W:0]   calib_win_o
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TAP_W-1:0] LAST_TAP     = TAP_W'(NUM_TAPS - 1);

   calib_state_t     state;
   logic [TAP_W-1:0] sweep_tap;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      delay_src;
   logic             abort;
   logic             score_valid;
   logic             start_ok;
   logic [TAP_W-1:0] best_start;
   logic [TAP_W:0]   best_len;
   logic [TAP_W-1:0] half_len;
   logic [TAP_W-1:0] centre_tap;

   // calib_tap_o doubles as the calibrated tap register; an all-fail sweep
   // leaves it untouched so the previous calibration stays in force.
   always_comb begin
      // NOTE: default assignment first so no path through this block leaves
      // delay_src unassigned, which would otherwise infer a latch.
      delay_src = 32'(calib_tap_o);
      if (cfg_manual_i) begin
         delay_src = cfg_delay_i;
      end else if (state != S_IDLE) begin
         delay_src = 32'(sweep_tap);
      end
   end

   assign abort       = cfg_manual_i && (state != S_IDLE);
   assign start_ok    = calib_start_i && !cfg_manual_i;
   assign score_valid = (state == S_WAIT) && !abort && (trn_done_i || (cnt == TIMEOUT_LAST));
   assign half_len    = TAP_W'((best_len - (TAP_W+1)'(1)) >> 1);
   assign centre_tap  = best_start + half_len;

   hyperbus_delay_window #(
      .TAP_W (TAP_W)
   ) u_window (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      ((state == S_IDLE) && start_ok),
      .score_i      (score_valid),
      .pass_i       (trn_done_i && trn_pass_i),
      .tap_i        (sweep_tap),
      .best_start_o (best_start),
      .best_len_o   (best_len)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         sweep_tap    <= '0;
         cnt          <= '0;
         trn_req_o    <= 1'b0;
         delay_o      <= '0;
         calib_busy_o <= 1'b0;
         calib_done_o <= 1'b0;
         calib_err_o  <= 1'b0;
         calib_tap_o  <= '0;
         calib_win_o  <= '0;
      end else begin
         calib_done_o <= 1'b0;
         // The delay mux only switches while no RWDS edge can be in flight.
         if (bus_idle_i) begin
            delay_o <= delay_src;
         end

         if (abort) begin
            state        <= S_IDLE;
            calib_busy_o <= 1'b0;
            trn_req_o    <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start_ok) begin
                     state        <= S_SET_TAP;
                     calib_busy_o <= 1'b1;
                     calib_err_o  <= 1'b0;
                     sweep_tap    <= '0;
                  end
               end
               S_SET_TAP: begin
                  if (bus_idle_i) begin
                     state <= S_SETTLE;
                     cnt   <= '0;
                  end
               end
               S_SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     state     <= S_REQ;
                     trn_req_o <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_REQ: begin
                  if (trn_gnt_i) begin
                     state     <= S_WAIT;
                     trn_req_o <= 1'b0;
                     cnt       <= '0;
                  end
               end
               S_WAIT: begin
                  if (score_valid) begin
                     if (sweep_tap == LAST_TAP) begin
                        state <= S_EVAL;
                     end else begin
                        state     <= S_SET_TAP;
                        sweep_tap <= sweep_tap + TAP_W'(1);
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_EVAL: begin
                  if (best_len == '0) begin
                     calib_err_o <= 1'b1;
                  end else begin
                     calib_tap_o <= centre_tap;
                     calib_win_o <= best_len;
                  end
                  state        <= S_DONE;
                  calib_done_o <= 1'b1;
               end
               S_DONE: begin
                  state        <= S_IDLE;
                  calib_busy_o <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hyperbus_delay_calib.sv
// Randomized bench for hyperbus_delay_calib: a training-read responder answers
// per-tap from a pass/fail/timeout pattern and a window model predicts the result.
module tb_hyperbus_delay_calib;

   localparam int NT     = 8;
   localparam int TW     = 3;
   localparam int TO_CYC = 48;
   localparam int FAILP  = 0;
   localparam int PASSP  = 1;
   localparam int TOUT   = 2;

   logic          clk_i         = 1'b0;
   logic          rst_ni        = 1'b0;
   logic          cfg_manual_i  = 1'b0;
   logic [31:0]   cfg_delay_i   = '0;
   logic          calib_start_i = 1'b0;
   logic          bus_idle_i    = 1'b1;
   logic          trn_gnt_i;
   logic          trn_done_i;
   logic          trn_pass_i;
   logic          trn_req_o;
   logic [31:0]   delay_o;
   logic          calib_busy_o;
   logic          calib_done_o;
   logic          calib_err_o;
   logic [TW-1:0] calib_tap_o;
   logic [TW:0]   calib_win_o;

   int          vectors     = 0;
   int          miscompares = 0;
   int          pattern[NT];
   int          idle_mode   = 1;
   int          done_count  = 0;
   logic [31:0] req_log[$];
   int          exp_tap     = 0;
   int          exp_win     = 0;
   int          exp_err     = 0;

   hyperbus_delay_calib #(
      .NUM_TAPS       (NT),
      .SETTLE_CYCLES  (4),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cfg_manual_i  (cfg_manual_i),
      .cfg_delay_i   (cfg_delay_i),
      .calib_start_i (calib_start_i),
      .bus_idle_i    (bus_idle_i),
      .trn_req_o     (trn_req_o),
      .trn_gnt_i     (trn_gnt_i),
      .trn_done_i    (trn_done_i),
      .trn_pass_i    (trn_pass_i),
      .delay_o       (delay_o),
      .calib_busy_o  (calib_busy_o),
      .calib_done_o  (calib_done_o),
      .calib_err_o   (calib_err_o),
      .calib_tap_o   (calib_tap_o),
      .calib_win_o   (calib_win_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Longest run of passing taps, earliest on ties; timeouts count as fails.
   function automatic void model(output int bs, output int bl);
      bs = 0;
      bl = 0;
      for (int s = 0; s < NT; s++) begin
         if (pattern[s] == PASSP && (s == 0 || pattern[(s > 0) ? s - 1 : 0] != PASSP)) begin
            int l = 0;
            while (s + l < NT && pattern[(s + l < NT) ? s + l : 0] == PASSP) l++;
            if (l > bl) begin
               bl = l;
               bs = s;
            end
         end
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (idle_mode)
            0:       bus_idle_i = 1'b0;
            1:       bus_idle_i = 1'b1;
            default: bus_idle_i = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   always @(negedge clk_i) begin
      if (calib_done_o) done_count++;
   end

   // Training-read responder: grants after a random delay, then answers per tap.
   initial begin
      int tap_idx;
      trn_gnt_i  = 1'b0;
      trn_done_i = 1'b0;
      trn_pass_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         trn_gnt_i  = 1'b0;
         trn_done_i = 1'b0;
         trn_pass_i = 1'($urandom_range(0, 1));
         if (trn_req_o) begin
            tap_idx = int'(delay_o[TW-1:0]);
            req_log.push_back(delay_o);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk_i);
               #1;
            end
            trn_gnt_i = 1'b1;
            @(posedge clk_i);
            #1;
            trn_gnt_i = 1'b0;
            if (pattern[tap_idx] != TOUT) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk_i);
                  #1;
               end
               trn_done_i = 1'b1;
               trn_pass_i = (pattern[tap_idx] == PASSP);
            end
         end
      end
   end

   task automatic set_pattern(input int first_pass, input int last_pass);
      for (int i = 0; i < NT; i++) pattern[i] = (i >= first_pass && i <= last_pass) ? PASSP : FAILP;
   endtask

   task automatic run_calib(input string tag);
      int bs, bl, d0;
      bit seen, order_ok;
      model(bs, bl);
      req_log.delete();
      @(negedge clk_i);
      d0            = done_count;
      idle_mode     = 2;
      calib_start_i = 1'b1;
      @(negedge clk_i);
      calib_start_i = 1'b0;
      check({tag, "_busy_hi"}, calib_busy_o, 1);
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk_i);
         if (calib_done_o) seen = 1'b1;
      end
      check({tag, "_done_seen"}, seen, 1);
      if (bl > 0) begin
         exp_tap = bs + (bl - 1) / 2;
         exp_win = bl;
         exp_err = 0;
      end else begin
         exp_err = 1;
      end
      check({tag, "_tap"}, calib_tap_o, exp_tap);
      check({tag, "_win"}, calib_win_o, exp_win);
      check({tag, "_err"}, calib_err_o, exp_err);
      @(negedge clk_i);
      check({tag, "_busy_lo"}, calib_busy_o, 0);
      check({tag, "_done_cnt"}, done_count - d0, 1);
      idle_mode = 1;
      repeat (2) @(negedge clk_i);
      check({tag, "_delay"}, delay_o, exp_tap);
      order_ok = (req_log.size() == NT);
      for (int i = 0; i < req_log.size(); i++) if (req_log[i] != i) order_ok = 1'b0;
      check({tag, "_sweep"}, order_ok, 1);
      repeat (8) @(negedge clk_i);
   endtask

   initial begin
      int d0;
      bit reached;

      // Reset
      repeat (3) @(negedge clk_i);
      check("rst_delay", delay_o, 0);
      check("rst_req", trn_req_o, 0);
      check("rst_busy", calib_busy_o, 0);
      check("rst_done", calib_done_o, 0);
      check("rst_err", calib_err_o, 0);
      check("rst_tap", calib_tap_o, 0);
      check("rst_win", calib_win_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Manual mode, including hold while the bus is busy
      cfg_manual_i = 1'b1;
      cfg_delay_i  = 32'd5;
      @(negedge clk_i);
      check("man_load5", delay_o, 5);
      idle_mode = 0;
      @(negedge clk_i);
      cfg_delay_i = 32'd3;
      @(negedge clk_i);
      check("man_hold_a", delay_o, 5);
      @(negedge clk_i);
      check("man_hold_b", delay_o, 5);
      idle_mode = 1;
      @(negedge clk_i);
      check("man_hold_c", delay_o, 5);
      @(negedge clk_i);
      check("man_load3", delay_o, 3);
      cfg_delay_i = 32'hdead_beef;
      @(negedge clk_i);
      check("man_wide", delay_o, 32'hdead_beef);
      cfg_manual_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("man_exit", delay_o, 0);

      // Directed windows
      set_pattern(2, 6);
      run_calib("single");
      set_pattern(4, 6);
      pattern[0] = PASSP;
      pattern[1] = PASSP;
      run_calib("multi");
      set_pattern(4, 6);
      pattern[0] = PASSP;
      pattern[1] = PASSP;
      pattern[2] = PASSP;
      run_calib("tie");
      set_pattern(4, 7);
      pattern[3] = TOUT;
      run_calib("timeout");

      // Randomized patterns
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < NT; i++) begin
            int r = $urandom_range(0, 9);
            pattern[i] = (r < 4) ? FAILP : (r < 9) ? PASSP : TOUT;
         end
         run_calib($sformatf("rand%0d", k));
      end

      // All fail after calibrating to tap 4
      set_pattern(2, 6);
      run_calib("pre_fail");
      for (int i = 0; i < NT; i++) pattern[i] = FAILP;
      pattern[5] = TOUT;
      run_calib("all_fail");
      set_pattern(0, 7);
      run_calib("recover");

      // Abort by raising manual during tap 3
      set_pattern(0, 7);
      req_log.delete();
      @(negedge clk_i);
      d0            = done_count;
      idle_mode     = 2;
      calib_start_i = 1'b1;
      @(negedge clk_i);
      calib_start_i = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         @(negedge clk_i);
         if (req_log.size() >= 4) reached = 1'b1;
      end
      check("abort_reach_tap3", reached, 1);
      check("abort_tap3_busy", calib_busy_o, 1);
      cfg_manual_i = 1'b1;
      cfg_delay_i  = 32'd6;
      @(negedge clk_i);
      check("abort_busy_lo", calib_busy_o, 0);
      repeat (4) @(negedge clk_i);
      check("abort_no_done", done_count - d0, 0);
      check("abort_err", calib_err_o, exp_err);
      check("abort_tap", calib_tap_o, exp_tap);
      check("abort_win", calib_win_o, exp_win);
      cfg_manual_i = 1'b0;
      idle_mode    = 1;
      repeat (2) @(negedge clk_i);
      check("abort_delay", delay_o, exp_tap);
      repeat (10) @(negedge clk_i);

      // Reset mid-sweep
      req_log.delete();
      idle_mode     = 2;
      calib_start_i = 1'b1;
      @(negedge clk_i);
      calib_start_i = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         @(negedge clk_i);
         if (req_log.size() >= 2) reached = 1'b1;
      end
      check("mrst_reach", reached, 1);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      check("mrst_delay", delay_o, 0);
      check("mrst_req", trn_req_o, 0);
      check("mrst_busy", calib_busy_o, 0);
      check("mrst_done", calib_done_o, 0);
      check("mrst_err", calib_err_o, 0);
      check("mrst_tap", calib_tap_o, 0);
      check("mrst_win", calib_win_o, 0);
      rst_ni    = 1'b1;
      idle_mode = 1;
      repeat (3) @(negedge clk_i);
      check("mrst_after_delay", delay_o, 0);
      check("mrst_after_busy", calib_busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
